// File: rtl/sseg_scan_if.sv
// Bus between the scan driver and whatever supplies the display value.
// The master supplies value/dp/load/err_clr and the slave (sseg_scan) returns the scan outputs.
interface sseg_scan_if;
    logic [23:0] value;
    logic [5:0]  dp;
    logic        load;
    logic        err_clr;
    logic [4:0]  digit;
    logic [2:0]  digit_pos;
    logic        frame_start;
    logic        bcd_err;

    modport master (
        output value, dp, load, err_clr,
        input  digit, digit_pos, frame_start, bcd_err
    );

    modport slave (
        input  value, dp, load, err_clr,
        output digit, digit_pos, frame_start, bcd_err
    );
endinterface

// File: rtl/sseg_scan.sv
// Six-digit seven-segment scan driver that presents one {dp, bcd} digit every DIV clocks.
// New values are double-buffered and committed only at the frame wrap.
module sseg_scan #(
    parameter int DIV   = 50000,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst_n,
    sseg_scan_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             wrap;
    logic [2:0]       pos;
    logic [2:0]       next_pos;

    logic [23:0]      act_value;
    logic [5:0]       act_dp;
    logic [23:0]      pend_value;
    logic [5:0]       pend_dp;
    logic             pend;

    logic [23:0]      src_value;
    logic [5:0]       src_dp;
    logic [3:0]       nib;
    logic             dp_bit;
    logic             nib_bad;

    logic [4:0]       digit_q;
    logic             frame_q;
    logic             err_q;

    assign tick     = (cnt == CNT_LAST);
    assign wrap     = tick && (pos == 3'd5);
    assign next_pos = (pos == 3'd5) ? 3'd0 : pos + 3'd1;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

    // Data for the digit about to be shown: at a wrap it is the post-commit value,
    // so position 0 of a new frame never shows stale digits.
    always_comb begin
        src_value = act_value;
        src_dp    = act_dp;
        if (wrap) begin
            if (bus.load) begin
                src_value = bus.value;
                src_dp    = bus.dp;
            end else if (pend) begin
                src_value = pend_value;
                src_dp    = pend_dp;
            end
        end
    end

    // NOTE: each output of this block gets a default first, so no latch is inferred.
    always_comb begin
        nib    = 4'd0;
        dp_bit = 1'b0;
        case (next_pos)
            3'd0: begin nib = src_value[23:20]; dp_bit = src_dp[5]; end
            3'd1: begin nib = src_value[19:16]; dp_bit = src_dp[4]; end
            3'd2: begin nib = src_value[15:12]; dp_bit = src_dp[3]; end
            3'd3: begin nib = src_value[11:8];  dp_bit = src_dp[2]; end
            3'd4: begin nib = src_value[7:4];   dp_bit = src_dp[1]; end
            3'd5: begin nib = src_value[3:0];   dp_bit = src_dp[0]; end
            default: begin nib = 4'd0; dp_bit = 1'b0; end
        endcase
        nib_bad = (nib > 4'd9);
    end

    // The display buffers are small registers, so they are reset along with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_value  <= '0;
            act_dp     <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
        end else begin
            if (wrap) begin
                act_value <= src_value;
                act_dp    <= src_dp;
            end
            if (wrap) begin
                pend <= 1'b0;
            end else if (bus.load) begin
                pend_value <= bus.value;
                pend_dp    <= bus.dp;
                pend       <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= 3'd0;
            digit_q <= 5'd0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            frame_q <= wrap;
            if (tick) begin
                pos     <= next_pos;
                digit_q <= {dp_bit, nib_bad ? 4'd0 : nib};
            end
            // A set always wins over a clear arriving in the same cycle.
            if (tick && nib_bad) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_pos   = pos;
    assign bus.frame_start = frame_q;
    assign bus.bcd_err     = err_q;
endmodule

// File: tb/tb_sseg_scan.sv
// Scoreboard bench for sseg_scan with DIV=4: a frame-level reference model queues each expected digit slot,
// and a monitor compares the queued slot whenever the DUT steps to a new position.
module tb_sseg_scan;
    localparam int DIV   = 4;
    localparam int FRAME = 6 * DIV;

    typedef struct packed {
        logic       fs;
        logic [2:0] pos;
        logic [4:0] digit;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sseg_scan_if bus();

    sseg_scan #(.DIV(DIV), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    slot_t exp_q[$];

    int          edge_n = 0;
    logic [23:0] latest_v = '0;
    logic [5:0]  latest_dp = '0;
    logic [23:0] frame_v = '0;
    logic [5:0]  frame_dp = '0;
    logic        exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame shows the most recent load sampled at or before its wrap edge.
    initial begin
        int          p;
        logic [3:0]  n;
        slot_t       s;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                edge_n    = 0;
                latest_v  = '0;
                latest_dp = '0;
                frame_v   = '0;
                frame_dp  = '0;
                exp_err   = 1'b0;
                exp_q.delete();
            end else begin
                edge_n++;
                if (bus.load) begin
                    latest_v  = bus.value;
                    latest_dp = bus.dp;
                end
                if (edge_n % DIV == 0) begin
                    p = (edge_n / DIV) % 6;
                    if (p == 0) begin
                        frame_v  = latest_v;
                        frame_dp = latest_dp;
                    end
                    n       = 4'((frame_v >> (4 * (5 - p))) & 24'hF);
                    s.fs    = (p == 0);
                    s.pos   = 3'(p);
                    s.digit = {frame_dp[5 - p], (n > 9) ? 4'd0 : n};
                    exp_q.push_back(s);
                    if (n > 9) exp_err = 1'b1;
                    else if (bus.err_clr) exp_err = 1'b0;
                end else if (bus.err_clr) begin
                    exp_err = 1'b0;
                end
            end
        end
    end

    // Monitor: a change of digit_pos marks a new slot on display.
    initial begin
        logic [2:0] last_pos = 3'd0;
        int         idle = 0;
        slot_t      e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_pos = 3'd0;
                idle = 0;
            end else begin
                if (bus.digit_pos != last_pos) begin
                    idle = 0;
                    last_pos = bus.digit_pos;
                    if (exp_q.size() == 0) begin
                        check("unexpected_slot", 32'(bus.digit_pos), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("slot", 32'({bus.frame_start, bus.digit_pos, bus.digit}), 32'(e));
                    end
                end else begin
                    idle++;
                    check("frame_start_idle", 32'(bus.frame_start), 32'd0);
                    if (idle > 2 * DIV) begin
                        check("scan_timeout", 32'(idle), 32'(DIV));
                        idle = 0;
                    end
                end
                check("bcd_err", 32'(bus.bcd_err), 32'(exp_err));
            end
        end
    end

    // Wait so that the next sampled edge has the given position within the frame.
    task automatic wait_mod(input int m);
        do @(negedge clk); while (((edge_n + 1) % FRAME) != m);
    endtask

    task automatic do_load(input logic [23:0] v, input logic [5:0] d, input int m);
        wait_mod(m);
        bus.value = v;
        bus.dp    = d;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digit"}, 32'(bus.digit), 32'd0);
        check({tag, "_pos"}, 32'(bus.digit_pos), 32'd0);
        check({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
        check({tag, "_err"}, 32'(bus.bcd_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] v;
        bus.value   = '0;
        bus.dp      = '0;
        bus.load    = 1'b0;
        bus.err_clr = 1'b0;

        // Reset state and free-running scan of zeros.
        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_edges(2 * FRAME);

        // Mid-frame load shows from the next frame only.
        do_load(24'h123456, 6'b000100, 9);
        run_edges(2 * FRAME);

        // Two loads in one frame: the latest wins.
        do_load(24'h111111, 6'b000000, 3);
        do_load(24'h999999, 6'b111111, 15);
        run_edges(FRAME + 5);

        // Load on the exact wrap edge bypasses the pending buffer.
        do_load(24'h654321, 6'b100001, 0);
        run_edges(2 * FRAME);

        // Non-BCD nibble: forced to 0, sticky error, cleared during pos 1, set again at pos 0.
        do_load(24'hA00000, 6'b000000, 10);
        wait_mod(6);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        run_edges(2 * FRAME);
        do_load(24'h000000, 6'b000000, 2);
        wait_mod(1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        run_edges(FRAME);

        // Randomized loads, including invalid nibbles and error clears.
        for (int i = 0; i < 30; i++) begin
            run_edges($urandom_range(1, 30));
            if ($urandom_range(0, 1) == 0) begin
                v = '0;
                for (int j = 0; j < 6; j++) v = {v[19:0], 4'($urandom_range(0, 9))};
            end else begin
                v = 24'($urandom);
            end
            bus.value   = v;
            bus.dp      = 6'($urandom);
            bus.load    = 1'b1;
            bus.err_clr = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            bus.load    = 1'b0;
            bus.err_clr = 1'b0;
        end
        run_edges(2 * FRAME);

        // Reset at position 3 with a load pending discards it.
        do_load(24'h777777, 6'b111111, 5);
        wait_mod(14);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_edges(2 * FRAME + 3);

        #2 check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
